// File: rtl/sc_spi_sync_filter.sv
// Multi-channel synchronizer, glitch filter and edge-strobe generator.
// Filter counters are built only when SC_SPI_SYNC_FILTER_EN is defined.
module sc_spi_sync_filter #(
  parameter int              CH       = 4,
  parameter int              STAGES   = 2,
  parameter int              FILT_CYC = 4,
  parameter logic [CH-1:0]   RST_VAL  = {CH{1'b0}}
) (
  input  logic          SYSCLK,
  input  logic          SYSRST,
  input  logic [CH-1:0] ASYNC_IN,
  output logic [CH-1:0] SYNC_OUT,
  output logic [CH-1:0] RISE,
  output logic [CH-1:0] FALL,
  output logic          CHG_ANY
);

  generate
    if (CH < 1 || CH > 32) begin : g_bad_ch
      $error("CH must be in 1..32");
    end
    if (STAGES < 2) begin : g_bad_stages
      $error("STAGES must be >= 2");
    end
    if (FILT_CYC < 1 || FILT_CYC > 255) begin : g_bad_filt
      $error("FILT_CYC must be in 1..255");
    end
  endgenerate

  logic [CH-1:0] chain_q [STAGES];
  logic [CH-1:0] s;
  logic [CH-1:0] acc;
  logic [CH-1:0] sync_q, sync_d;
  logic [CH-1:0] rise_q, rise_d;
  logic [CH-1:0] fall_q, fall_d;

  always_ff @(posedge SYSCLK or posedge SYSRST) begin
    if (SYSRST) begin
      for (int k = 0; k < STAGES; k++) begin
        chain_q[k] <= RST_VAL;
      end
    end else begin
      chain_q[0] <= ASYNC_IN;
      for (int k = 1; k < STAGES; k++) begin
        chain_q[k] <= chain_q[k-1];
      end
    end
  end

  assign s = chain_q[STAGES-1];

`ifdef SC_SPI_SYNC_FILTER_EN
  localparam int CW = $clog2(FILT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(FILT_CYC - 1);

  logic [CW-1:0] cnt_q [CH];
  logic [CW-1:0] cnt_d [CH];

  // A new level is accepted on the FILT_CYC-th consecutive differing cycle.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      cnt_d[i] = '0;
      acc[i]   = 1'b0;
      if (s[i] != sync_q[i]) begin
        if (cnt_q[i] == LAST) begin
          acc[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge SYSCLK or posedge SYSRST) begin
    if (SYSRST) begin
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
`else
  assign acc = s ^ sync_q;
`endif

  assign sync_d = sync_q ^ acc;
  assign rise_d = acc & s;
  assign fall_d = acc & ~s;

  always_ff @(posedge SYSCLK or posedge SYSRST) begin
    if (SYSRST) begin
      sync_q <= RST_VAL;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      sync_q <= sync_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign SYNC_OUT = sync_q;
  assign RISE     = rise_q;
  assign FALL     = fall_q;
  assign CHG_ANY  = |(rise_q | fall_q);

endmodule

// File: tb/tb_sc_spi_sync_filter.sv
// Bench for sc_spi_sync_filter: two instances (STAGES=2 and 3)
// checked every cycle against a window-based reference via queues.
module tb_sc_spi_sync_filter;

`ifdef SC_SPI_SYNC_FILTER_EN
  localparam int FE = 4;
`else
  localparam int FE = 1;
`endif

  logic       SYSCLK = 1'b0;
  logic       SYSRST = 1'b0;
  logic [3:0] ASYNC_IN = 4'b0101;

  logic [3:0] so_a, ri_a, fa_a;
  logic       ch_a;
  logic [3:0] so_b, ri_b, fa_b;
  logic       ch_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [12:0] qa[$];
  logic [12:0] qb[$];

  logic [3:0] m_pipe [2][3];
  logic [3:0] m_win  [2][4];
  logic [3:0] m_out  [2];

  always #5 SYSCLK = ~SYSCLK;

  sc_spi_sync_filter #(
    .CH(4), .STAGES(2), .FILT_CYC(4), .RST_VAL(4'b0101)
  ) dut_a (
    .SYSCLK(SYSCLK), .SYSRST(SYSRST), .ASYNC_IN(ASYNC_IN),
    .SYNC_OUT(so_a), .RISE(ri_a), .FALL(fa_a), .CHG_ANY(ch_a)
  );

  sc_spi_sync_filter #(
    .CH(4), .STAGES(3), .FILT_CYC(4), .RST_VAL(4'b0000)
  ) dut_b (
    .SYSCLK(SYSCLK), .SYSRST(SYSRST), .ASYNC_IN(ASYNC_IN),
    .SYNC_OUT(so_b), .RISE(ri_b), .FALL(fa_b), .CHG_ANY(ch_b)
  );

  function automatic int st(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic logic [3:0] rstv(input int d);
    return (d == 0) ? 4'b0101 : 4'b0000;
  endfunction

  task automatic model_reset(input int d);
    for (int k = 0; k < 3; k++) m_pipe[d][k] = rstv(d);
    for (int j = 0; j < 4; j++) m_win[d][j] = rstv(d);
    m_out[d] = rstv(d);
  endtask

  // Output flips once the last FE samples of s all differ from it.
  task automatic model_edge(input int d, input logic [3:0] vin,
                            output logic [12:0] e);
    logic [3:0] sold, acc;
    if (SYSRST) begin
      model_reset(d);
      e = {rstv(d), 9'b0};
      return;
    end
    sold = m_pipe[d][st(d)-1];
    for (int k = 2; k > 0; k--) m_pipe[d][k] = m_pipe[d][k-1];
    m_pipe[d][0] = vin;
    for (int j = 3; j > 0; j--) m_win[d][j] = m_win[d][j-1];
    m_win[d][0] = sold;
    acc = 4'hF;
    for (int j = 0; j < FE; j++) acc &= m_win[d][j] ^ m_out[d];
    m_out[d] = m_out[d] ^ acc;
    e = {m_out[d], acc & sold, acc & ~sold, |acc};
  endtask

  task automatic check(input string tag, input logic [12:0] o,
                       input logic [12:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic step(input logic [3:0] v);
    logic [12:0] ea, eb;
    ASYNC_IN = v;
    model_edge(0, v, ea);
    qa.push_back(ea);
    model_edge(1, v, eb);
    qb.push_back(eb);
    @(posedge SYSCLK);
    #1;
    check("cyc_a", {so_a, ri_a, fa_a, ch_a}, qa.pop_front());
    check("cyc_b", {so_b, ri_b, fa_b, ch_b}, qb.pop_front());
  endtask

  task automatic hold(input logic [3:0] v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  initial begin
    // Reset with inputs already at the dut_a reset level
    #1 SYSRST = 1'b1;
    #1;
    check("rst_a", {so_a, ri_a, fa_a, ch_a}, {4'b0101, 9'b0});
    check("rst_b", {so_b, ri_b, fa_b, ch_b}, {4'b0000, 9'b0});
    model_reset(0);
    model_reset(1);
    hold(4'b0101, 3);
    SYSRST = 1'b0;
    hold(4'b0101, 12);

    // Latency: ch0 fall then rise
    hold(4'b0100, 10);
    hold(4'b0101, 10);

    // Glitch on ch1: 3 cycles then 4 cycles
    hold(4'b0111, 3);
    hold(4'b0101, 10);
    check("glitch3_a", {3'b0, so_a[1]}, 4'b0);
    hold(4'b0111, 4);
    hold(4'b0101, 12);

    // Bounce on ch2
    hold(4'b0001, 2);
    hold(4'b0101, 1);
    hold(4'b0001, 10);
    hold(4'b0101, 10);

    // All channels toggle together
    hold(4'b1010, 10);
    hold(4'b0101, 3);

    // Async reset mid-count
    SYSRST = 1'b1;
    #1;
    check("midrst_a", {so_a, ri_a, fa_a, ch_a}, {4'b0101, 9'b0});
    check("midrst_b", {so_b, ri_b, fa_b, ch_b}, {4'b0000, 9'b0});
    model_reset(0);
    model_reset(1);
    hold(4'b0101, 2);
    SYSRST = 1'b0;
    hold(4'b0101, 12);
    check("postrst_a", {so_a, ri_a, fa_a, ch_a}, {4'b0101, 9'b0});

    // Random segments
    for (int n = 0; n < 40; n++) begin
      hold(4'($urandom), $urandom_range(1, 6));
    end
    hold(4'b0000, 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
